fwd_opnd_unit: RTL and testbench

Parametrised operand-forwarding and load-use interlock unit for the RR→EX boundary of the pipelined core. It supports N source operands and N producer stages, forwarding from the youngest matching writer. It stalls RR when the youngest match is a load whose data is not yet available, and registers the resolved operands into the EX operand register. It also keeps saturating stall/forward counters and a sticky stall-watchdog error.

---
 rtl/fwd_pkg.sv | 26 ++
 rtl/fwd_prio_sel.sv | 34 +++
 rtl/fwd_opnd_unit.sv | 149 ++++++++++++++
 tb/tb_fwd_opnd_unit.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fwd_pkg.sv
// Shared constants, types and helpers for the operand-forwarding unit.
package fwd_pkg;

    // Default parameter values
    localparam int unsigned DEF_DATA_W    = 16;
    localparam int unsigned DEF_REG_AW    = 3;
    localparam int unsigned DEF_NSRC      = 2;
    localparam int unsigned DEF_NSTG      = 3;
    localparam int unsigned DEF_LD_RDY    = 1;
    localparam int unsigned DEF_MAX_STALL = 4;
    localparam int unsigned DEF_CNT_W     = 16;

    // Select value 0 picks the register bank; s+1 picks producer stage s.
    localparam int unsigned SEL_RF = 0;

    // Width of one operand select field
    function automatic int unsigned SELW(input int unsigned nstg);
        return $clog2(nstg + 1);
    endfunction

    typedef enum logic [0:0] {
        StRun   = 1'b0,
        StStall = 1'b1
    } fwd_state_e;

endpackage

// File: rtl/fwd_prio_sel.sv
// Youngest-match priority encoder for a single source operand.
module fwd_prio_sel
    import fwd_pkg::*;
#(
    parameter int unsigned NSTG   = DEF_NSTG,
    parameter int unsigned REG_AW = DEF_REG_AW,
    parameter int unsigned LD_RDY = DEF_LD_RDY,
    parameter int unsigned SW     = SELW(NSTG)
) (
    input  logic                   src_vld_i,
    input  logic [REG_AW-1:0]      src_addr_i,
    input  logic [NSTG-1:0]        stg_wen_i,
    input  logic [NSTG*REG_AW-1:0] stg_rd_i,
    input  logic [NSTG-1:0]        stg_ld_i,
    output logic [SW-1:0]          sel_o,
    output logic                   hazard_o
);

    // Scan oldest to youngest so the youngest matching writer overrides
    always_comb begin
        sel_o    = SW'(SEL_RF);
        hazard_o = 1'b0;
        if (src_vld_i) begin
            for (int s = NSTG - 1; s >= 0; s--) begin
                if (stg_wen_i[s] && (stg_rd_i[s*REG_AW +: REG_AW] == src_addr_i)) begin
                    sel_o    = SW'(s + 1);
                    // Load data is not on the bypass bus before stage LD_RDY
                    hazard_o = stg_ld_i[s] && (unsigned'(s) < LD_RDY);
                end
            end
        end
    end

endmodule

// File: rtl/fwd_opnd_unit.sv
// Operand forwarding, load-use interlock and EX operand register.
module fwd_opnd_unit
    import fwd_pkg::*;
#(
    parameter int unsigned DATA_W    = DEF_DATA_W,
    parameter int unsigned REG_AW    = DEF_REG_AW,
    parameter int unsigned NSRC      = DEF_NSRC,
    parameter int unsigned NSTG      = DEF_NSTG,
    parameter int unsigned LD_RDY    = DEF_LD_RDY,
    parameter int unsigned MAX_STALL = DEF_MAX_STALL,
    parameter int unsigned CNT_W     = DEF_CNT_W
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     flush_i,
    input  logic                     hold_i,
    input  logic [NSRC-1:0]          src_vld_i,
    input  logic [NSRC*REG_AW-1:0]   src_addr_i,
    input  logic [NSRC*DATA_W-1:0]   rf_data_i,
    input  logic [NSTG-1:0]          stg_wen_i,
    input  logic [NSTG*REG_AW-1:0]   stg_rd_i,
    input  logic [NSTG-1:0]          stg_ld_i,
    input  logic [NSTG*DATA_W-1:0]   stg_data_i,
    output logic                     stall_o,
    output logic [NSRC*SELW(NSTG)-1:0] fwd_sel_o,
    output logic [NSRC*DATA_W-1:0]   opnd_q_o,
    output logic                     opnd_vld_o,
    output logic [CNT_W-1:0]         stall_cnt_o,
    output logic [CNT_W-1:0]         fwd_cnt_o,
    output logic                     err_o
);

    localparam int unsigned SW = SELW(NSTG);
    localparam int unsigned RW = $clog2(MAX_STALL + 1);

    logic [SW-1:0]          w_sel [NSRC];
    logic [NSRC-1:0]        w_hazard;
    logic [NSRC-1:0]        w_sel_nz;
    logic [NSRC*DATA_W-1:0] w_opnd_mux;
    logic                   w_advance;

    fwd_state_e             r_state, w_state_d;
    logic [RW-1:0]          r_stall_run, w_stall_run_d;
    logic [NSRC*DATA_W-1:0] r_opnd_q;
    logic                   r_opnd_vld;
    logic [CNT_W-1:0]       r_stall_cnt;
    logic [CNT_W-1:0]       r_fwd_cnt;
    logic                   r_err;

    for (genvar k = 0; k < NSRC; k++) begin : g_src
        fwd_prio_sel #(
            .NSTG   (NSTG),
            .REG_AW (REG_AW),
            .LD_RDY (LD_RDY),
            .SW     (SW)
        ) u_sel (
            .src_vld_i  (src_vld_i[k]),
            .src_addr_i (src_addr_i[k*REG_AW +: REG_AW]),
            .stg_wen_i  (stg_wen_i),
            .stg_rd_i   (stg_rd_i),
            .stg_ld_i   (stg_ld_i),
            .sel_o      (w_sel[k]),
            .hazard_o   (w_hazard[k])
        );
        assign fwd_sel_o[k*SW +: SW] = w_sel[k];
        assign w_sel_nz[k]           = (w_sel[k] != SW'(SEL_RF));
    end

    // Operand data mux: bank by default, stage s when select is s+1
    always_comb begin
        w_opnd_mux = rf_data_i;
        for (int k = 0; k < NSRC; k++) begin
            for (int s = 0; s < NSTG; s++) begin
                if (w_sel[k] == SW'(s + 1)) begin
                    w_opnd_mux[k*DATA_W +: DATA_W] = stg_data_i[s*DATA_W +: DATA_W];
                end
            end
        end
    end

    assign stall_o   = (|w_hazard) && !flush_i;
    assign w_advance = !flush_i && !hold_i && !stall_o;

    // Next state and consecutive-stall run length (saturating at MAX_STALL)
    always_comb begin
        w_state_d     = r_state;
        w_stall_run_d = r_stall_run;
        unique case (r_state)
            StRun:   if (stall_o) w_state_d = StStall;
            StStall: if (!stall_o || flush_i) w_state_d = StRun;
            default: w_state_d = StRun;
        endcase
        if (w_state_d == StStall) begin
            if (r_stall_run != RW'(MAX_STALL)) w_stall_run_d = r_stall_run + RW'(1);
        end else begin
            w_stall_run_d = '0;
        end
    end

    // FSM state, watchdog run length and sticky error
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= StRun;
            r_stall_run <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_stall_run <= w_stall_run_d;
            if (w_stall_run_d == RW'(MAX_STALL)) r_err <= 1'b1;
        end
    end

    // EX operand register: flush > hold > stall (bubble) > advance
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_opnd_q   <= '0;
            r_opnd_vld <= 1'b0;
        end else if (flush_i) begin
            r_opnd_q   <= '0;
            r_opnd_vld <= 1'b0;
        end else if (hold_i) begin
            r_opnd_q   <= r_opnd_q;
            r_opnd_vld <= r_opnd_vld;
        end else if (stall_o) begin
            r_opnd_vld <= 1'b0;
        end else begin
            r_opnd_q   <= w_opnd_mux;
            r_opnd_vld <= 1'b1;
        end
    end

    // Saturating statistics counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_stall_cnt <= '0;
            r_fwd_cnt   <= '0;
        end else begin
            if (stall_o && !hold_i && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
            if (w_advance && (|w_sel_nz) && (r_fwd_cnt != '1)) r_fwd_cnt <= r_fwd_cnt + 1'b1;
        end
    end

    assign opnd_q_o    = r_opnd_q;
    assign opnd_vld_o  = r_opnd_vld;
    assign stall_cnt_o = r_stall_cnt;
    assign fwd_cnt_o   = r_fwd_cnt;
    assign err_o       = r_err;

endmodule

// File: tb/tb_fwd_opnd_unit.sv
// Directed bench for fwd_opnd_unit with a queue of expected register states.
module tb_fwd_opnd_unit;

    localparam int unsigned DATA_W = 16;
    localparam int unsigned REG_AW = 3;
    localparam int unsigned NSRC   = 2;
    localparam int unsigned NSTG   = 3;
    localparam int unsigned SW     = 2;
    localparam int unsigned CNT_W  = 16;

    typedef struct {
        logic [15:0] q0;
        logic [15:0] q1;
        logic        vld;
        logic [15:0] scnt;
        logic [15:0] fcnt;
        logic        err;
    } exp_t;

    logic                   clk;
    logic                   reset_n;
    logic                   flush_i;
    logic                   hold_i;
    logic [NSRC-1:0]        src_vld_i;
    logic [NSRC*REG_AW-1:0] src_addr_i;
    logic [NSRC*DATA_W-1:0] rf_data_i;
    logic [NSTG-1:0]        stg_wen_i;
    logic [NSTG*REG_AW-1:0] stg_rd_i;
    logic [NSTG-1:0]        stg_ld_i;
    logic [NSTG*DATA_W-1:0] stg_data_i;
    logic                   stall_o;
    logic [NSRC*SW-1:0]     fwd_sel_o;
    logic [NSRC*DATA_W-1:0] opnd_q_o;
    logic                   opnd_vld_o;
    logic [CNT_W-1:0]       stall_cnt_o;
    logic [CNT_W-1:0]       fwd_cnt_o;
    logic                   err_o;

    int   n_checks = 0;
    int   n_errors = 0;
    exp_t sb[$];

    fwd_opnd_unit #(
        .DATA_W    (DATA_W),
        .REG_AW    (REG_AW),
        .NSRC      (NSRC),
        .NSTG      (NSTG),
        .LD_RDY    (1),
        .MAX_STALL (4),
        .CNT_W     (CNT_W)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .flush_i     (flush_i),
        .hold_i      (hold_i),
        .src_vld_i   (src_vld_i),
        .src_addr_i  (src_addr_i),
        .rf_data_i   (rf_data_i),
        .stg_wen_i   (stg_wen_i),
        .stg_rd_i    (stg_rd_i),
        .stg_ld_i    (stg_ld_i),
        .stg_data_i  (stg_data_i),
        .stall_o     (stall_o),
        .fwd_sel_o   (fwd_sel_o),
        .opnd_q_o    (opnd_q_o),
        .opnd_vld_o  (opnd_vld_o),
        .stall_cnt_o (stall_cnt_o),
        .fwd_cnt_o   (fwd_cnt_o),
        .err_o       (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [15:0] q0, input logic [15:0] q1, input logic vld,
                        input logic [15:0] scnt, input logic [15:0] fcnt, input logic err);
        exp_t e;
        e.q0 = q0; e.q1 = q1; e.vld = vld; e.scnt = scnt; e.fcnt = fcnt; e.err = err;
        sb.push_back(e);
    endtask

    // Clock edge, then compare registered outputs with the oldest expectation
    task automatic tick(input string tag);
        exp_t e;
        @(posedge clk);
        #1;
        e = sb.pop_front();
        chk({tag, ".q0"},   32'(opnd_q_o[15:0]),  32'(e.q0));
        chk({tag, ".q1"},   32'(opnd_q_o[31:16]), 32'(e.q1));
        chk({tag, ".vld"},  32'(opnd_vld_o),      32'(e.vld));
        chk({tag, ".scnt"}, 32'(stall_cnt_o),     32'(e.scnt));
        chk({tag, ".fcnt"}, 32'(fwd_cnt_o),       32'(e.fcnt));
        chk({tag, ".err"},  32'(err_o),           32'(e.err));
    endtask

    task automatic clr_stg();
        stg_wen_i  = '0;
        stg_rd_i   = '0;
        stg_ld_i   = '0;
        stg_data_i = '0;
    endtask

    initial begin
        reset_n    = 1'b0;
        flush_i    = 1'b0;
        hold_i     = 1'b0;
        src_vld_i  = '0;
        src_addr_i = '0;
        rf_data_i  = '0;
        clr_stg();
        #3;
        chk("rst.q",    32'(opnd_q_o),    32'h0);
        chk("rst.vld",  32'(opnd_vld_o),  32'h0);
        chk("rst.scnt", 32'(stall_cnt_o), 32'h0);
        chk("rst.fcnt", 32'(fwd_cnt_o),   32'h0);
        chk("rst.err",  32'(err_o),       32'h0);
        #5;
        reset_n = 1'b1;
        @(posedge clk);
        #1;

        // No match: operand 0 from the bank
        src_vld_i  = 2'b01;
        src_addr_i = {3'd0, 3'd3};
        rf_data_i  = {16'h0011, 16'h1234};
        #1;
        chk("nomatch.sel",   32'(fwd_sel_o), 32'h0);
        chk("nomatch.stall", 32'(stall_o),   32'h0);
        push(16'h1234, 16'h0011, 1'b1, 16'd0, 16'd0, 1'b0);
        tick("nomatch");

        // EX and WB both write r2: EX wins
        src_addr_i = {3'd0, 3'd2};
        stg_wen_i  = 3'b101;
        stg_rd_i   = {3'd2, 3'd0, 3'd2};
        stg_data_i = {16'h5555, 16'h0000, 16'hAAAA};
        #1;
        chk("young.sel", 32'(fwd_sel_o), 32'h1);
        push(16'hAAAA, 16'h0011, 1'b1, 16'd0, 16'd1, 1'b0);
        tick("young");

        // Only WB writes; EX has the same address but wen=0
        stg_wen_i = 3'b100;
        #1;
        chk("wbonly.sel", 32'(fwd_sel_o), 32'h3);
        push(16'h5555, 16'h0011, 1'b1, 16'd0, 16'd2, 1'b0);
        tick("wbonly");

        // Load-use on operand 1: load to r4 in EX
        clr_stg();
        src_vld_i  = 2'b10;
        src_addr_i = {3'd4, 3'd3};
        stg_wen_i  = 3'b001;
        stg_ld_i   = 3'b001;
        stg_rd_i   = {3'd0, 3'd0, 3'd4};
        stg_data_i = {16'h0000, 16'h0000, 16'hDEAD};
        #1;
        chk("ldu.stall", 32'(stall_o),   32'h1);
        chk("ldu.sel",   32'(fwd_sel_o), 32'h4);
        push(16'h5555, 16'h0011, 1'b0, 16'd1, 16'd2, 1'b0);
        tick("ldu_bubble");

        // Load moves to MEM: forwarded from stage 1
        stg_ld_i   = 3'b010;
        stg_wen_i  = 3'b010;
        stg_rd_i   = {3'd0, 3'd4, 3'd0};
        stg_data_i = {16'h0000, 16'hBEEF, 16'h0000};
        #1;
        chk("ldmem.stall", 32'(stall_o),   32'h0);
        chk("ldmem.sel",   32'(fwd_sel_o), 32'h8);
        push(16'h1234, 16'hBEEF, 1'b1, 16'd1, 16'd3, 1'b0);
        tick("ldmem");

        // Watchdog: hazard under hold for four edges
        stg_wen_i  = 3'b001;
        stg_ld_i   = 3'b001;
        stg_rd_i   = {3'd0, 3'd0, 3'd4};
        stg_data_i = '0;
        hold_i     = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("wd.stall", 32'(stall_o), 32'h1);
            push(16'h1234, 16'hBEEF, 1'b1, 16'd1, 16'd3, (i == 3));
            tick("wd");
        end
        hold_i = 1'b0;
        clr_stg();
        push(16'h1234, 16'h0011, 1'b1, 16'd1, 16'd3, 1'b1);
        tick("wd_sticky");

        // Flush during a stall
        stg_wen_i = 3'b001;
        stg_ld_i  = 3'b001;
        stg_rd_i  = {3'd0, 3'd0, 3'd4};
        push(16'h1234, 16'h0011, 1'b0, 16'd2, 16'd3, 1'b1);
        tick("fl_stall");
        flush_i = 1'b1;
        #1;
        chk("fl.stall", 32'(stall_o), 32'h0);
        push(16'h0000, 16'h0000, 1'b0, 16'd2, 16'd3, 1'b1);
        tick("flush");
        flush_i = 1'b0;
        clr_stg();

        // Forward four times to bring fwd_cnt to 7
        src_vld_i  = 2'b01;
        src_addr_i = {3'd0, 3'd2};
        for (int i = 0; i < 4; i++) begin
            stg_wen_i  = 3'b001;
            stg_rd_i   = {3'd0, 3'd0, 3'd2};
            stg_data_i = {16'h0000, 16'h0000, 16'(16'h0100 + i)};
            push(16'(16'h0100 + i), 16'h0011, 1'b1, 16'd2, 16'(4 + i), 1'b1);
            tick("fwd");
        end

        // Asynchronous reset between clock edges
        #2;
        reset_n = 1'b0;
        #1;
        chk("arst.q",    32'(opnd_q_o),    32'h0);
        chk("arst.vld",  32'(opnd_vld_o),  32'h0);
        chk("arst.scnt", 32'(stall_cnt_o), 32'h0);
        chk("arst.fcnt", 32'(fwd_cnt_o),   32'h0);
        chk("arst.err",  32'(err_o),       32'h0);
        #5;
        reset_n = 1'b1;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
